// File: rtl/ram_wb_if.sv
// ram_wb_if: bus between the execute stage (master) and the CPU15 data-memory write side (slave).
//  Request (master -> slave): CLR_REQ, RAM_WEN, RAM_AD_IN[AW], RAM_IN[DW]
//  Status  (slave -> master): RAM_0..RAM_7[DW], IO64_OUT[DW], BUSY, WR_DROP
//  Optional (macro RAM_WB_IO64_STB_EN): IO64_STB
interface ram_wb_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
);
  logic          CLR_REQ;
  logic          RAM_WEN;
  logic [AW-1:0] RAM_AD_IN;
  logic [DW-1:0] RAM_IN;
  logic [DW-1:0] RAM_0, RAM_1, RAM_2, RAM_3, RAM_4, RAM_5, RAM_6, RAM_7;
  logic [DW-1:0] IO64_OUT;
  logic          BUSY;
  logic          WR_DROP;
`ifdef RAM_WB_IO64_STB_EN
  logic          IO64_STB;
`endif

  modport master (
    output CLR_REQ, RAM_WEN, RAM_AD_IN, RAM_IN,
    input  RAM_0, RAM_1, RAM_2, RAM_3, RAM_4, RAM_5, RAM_6, RAM_7,
    input  IO64_OUT, BUSY, WR_DROP
`ifdef RAM_WB_IO64_STB_EN
    , input IO64_STB
`endif
  );

  modport slave (
    input  CLR_REQ, RAM_WEN, RAM_AD_IN, RAM_IN,
    output RAM_0, RAM_1, RAM_2, RAM_3, RAM_4, RAM_5, RAM_6, RAM_7,
    output IO64_OUT, BUSY, WR_DROP
`ifdef RAM_WB_IO64_STB_EN
    , output IO64_STB
`endif
  );
endinterface

// File: rtl/ram_wb.sv
// ram_wb: write side of the CPU15 data memory.
//  Holds the 8-word data RAM (RAM_0..RAM_7) and the IO64 output latch, applies
//  store requests and runs an 8-cycle sequential clear on CLR_REQ.
// Ports:
//  CLK_WB  in  clock, all state updates on posedge
//  RESET   in  synchronous, active-high reset
//  bus     ram_wb_if.slave (CLR_REQ, RAM_WEN, RAM_AD_IN, RAM_IN in;
//          RAM_0..7, IO64_OUT, BUSY, WR_DROP out, all registered)
// Optional feature macro: RAM_WB_IO64_STB_EN adds IO64_STB, a 1-cycle pulse
//  coincident with every accepted IO64 store.
module ram_wb #(
  parameter int unsigned    DW        = 16,
  parameter int unsigned    AW        = 8,
  parameter logic [AW-1:0]  IO64_ADDR = 8'h40
) (
  input logic     CLK_WB,
  input logic     RESET,
  ram_wb_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        r_state;
  logic [2:0]    r_clr_cnt;
  logic [DW-1:0] r_ram [8];
  logic [DW-1:0] r_io64;
  logic          r_busy;
  logic          r_wr_drop;
`ifdef RAM_WB_IO64_STB_EN
  logic          r_io64_stb;
`endif

  logic w_addr_ram;
  logic w_addr_io64;

  assign w_addr_ram  = (bus.RAM_AD_IN < AW'(8));
  assign w_addr_io64 = (bus.RAM_AD_IN == IO64_ADDR);

  always_ff @(posedge CLK_WB) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
      for (int unsigned i = 0; i < 8; i++) r_ram[i] <= '0;
      r_io64    <= '0;
      r_busy    <= 1'b0;
      r_wr_drop <= 1'b0;
`ifdef RAM_WB_IO64_STB_EN
      r_io64_stb <= 1'b0;
`endif
    end else begin
      r_wr_drop <= 1'b0;
`ifdef RAM_WB_IO64_STB_EN
      r_io64_stb <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (bus.CLR_REQ) begin
            // Clear wins over a simultaneous store.
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
            r_wr_drop <= bus.RAM_WEN;
          end else if (bus.RAM_WEN) begin
            if (w_addr_ram) begin
              r_ram[bus.RAM_AD_IN[2:0]] <= bus.RAM_IN;
            end else if (w_addr_io64) begin
              r_io64 <= bus.RAM_IN;
`ifdef RAM_WB_IO64_STB_EN
              r_io64_stb <= 1'b1;
`endif
            end else begin
              r_wr_drop <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          // Stores and further clear requests are not accepted while clearing.
          r_ram[r_clr_cnt] <= '0;
          r_clr_cnt        <= r_clr_cnt + 3'd1;
          r_wr_drop        <= bus.RAM_WEN;
          if (r_clr_cnt == 3'd7) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.RAM_0    = r_ram[0];
  assign bus.RAM_1    = r_ram[1];
  assign bus.RAM_2    = r_ram[2];
  assign bus.RAM_3    = r_ram[3];
  assign bus.RAM_4    = r_ram[4];
  assign bus.RAM_5    = r_ram[5];
  assign bus.RAM_6    = r_ram[6];
  assign bus.RAM_7    = r_ram[7];
  assign bus.IO64_OUT = r_io64;
  assign bus.BUSY     = r_busy;
  assign bus.WR_DROP  = r_wr_drop;
`ifdef RAM_WB_IO64_STB_EN
  assign bus.IO64_STB = r_io64_stb;
`endif

endmodule

// File: tb/tb_ram_wb.sv
// tb_ram_wb: randomized self-checking bench for ram_wb against a behavioural
//  model (array of words, IO latch, remaining-clear-cycles count).
module tb_ram_wb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ram_wb_if #(.DW(16), .AW(8)) bus ();

  ram_wb #(.DW(16), .AW(8), .IO64_ADDR(8'h40)) dut (
    .CLK_WB (clk),
    .RESET  (rst),
    .bus    (bus)
  );

`ifdef RAM_WB_IO64_STB_EN
  localparam int VW = 8*16 + 16 + 3;
`else
  localparam int VW = 8*16 + 16 + 2;
`endif

  // Behavioural model
  logic [15:0] m_ram [8];
  logic [15:0] m_io;
  int          m_clear_left;
  logic        m_drop;
  logic        m_stb;

  function automatic logic [VW-1:0] dut_vec();
`ifdef RAM_WB_IO64_STB_EN
    return {bus.RAM_0, bus.RAM_1, bus.RAM_2, bus.RAM_3, bus.RAM_4, bus.RAM_5,
            bus.RAM_6, bus.RAM_7, bus.IO64_OUT, bus.BUSY, bus.WR_DROP, bus.IO64_STB};
`else
    return {bus.RAM_0, bus.RAM_1, bus.RAM_2, bus.RAM_3, bus.RAM_4, bus.RAM_5,
            bus.RAM_6, bus.RAM_7, bus.IO64_OUT, bus.BUSY, bus.WR_DROP};
`endif
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic busy;
    busy = (m_clear_left > 0);
`ifdef RAM_WB_IO64_STB_EN
    return {m_ram[0], m_ram[1], m_ram[2], m_ram[3], m_ram[4], m_ram[5],
            m_ram[6], m_ram[7], m_io, busy, m_drop, m_stb};
`else
    return {m_ram[0], m_ram[1], m_ram[2], m_ram[3], m_ram[4], m_ram[5],
            m_ram[6], m_ram[7], m_io, busy, m_drop};
`endif
  endfunction

  task automatic model_step(input logic r, input logic clr, input logic wen,
                            input logic [7:0] a, input logic [15:0] d);
    m_drop = 1'b0;
    m_stb  = 1'b0;
    if (r) begin
      for (int i = 0; i < 8; i++) m_ram[i] = 16'h0;
      m_io = 16'h0;
      m_clear_left = 0;
    end else if (m_clear_left > 0) begin
      m_ram[8 - m_clear_left] = 16'h0;
      m_clear_left--;
      m_drop = wen;
    end else if (clr) begin
      m_clear_left = 8;
      m_drop = wen;
    end else if (wen) begin
      if (a < 8)          m_ram[a] = d;
      else if (a == 8'h40) begin m_io = d; m_stb = 1'b1; end
      else                m_drop = 1'b1;
    end
  endtask

  // One clock: apply inputs, take the edge, advance the model, settle 1 time unit.
  task automatic cycle(input logic r, input logic clr, input logic wen,
                       input logic [7:0] a, input logic [15:0] d);
    rst = r;
    bus.CLR_REQ = clr;
    bus.RAM_WEN = wen;
    bus.RAM_AD_IN = a;
    bus.RAM_IN = d;
    @(posedge clk);
    model_step(r, clr, wen, a, d);
    #1;
    rst = 1'b0;
    bus.CLR_REQ = 1'b0;
    bus.RAM_WEN = 1'b0;
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(0, 7));
      1:       return 8'h40;
      2:       return 8'h41;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 8'h03, 16'hFFFF);
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL reset got=%h exp=%h", dut_vec(), model_vec());
    end
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_zero got=%h exp=0", dut_vec());
    end
  endtask

  task automatic test_store();
    cycle(0, 0, 1, 8'h03, 16'h1234);
    n_checks++;
    if (bus.RAM_3 !== 16'h1234 || bus.WR_DROP !== 1'b0 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL store_addr3 got=%h exp=%h", dut_vec(), model_vec());
    end
    for (int i = 0; i < 60; i++) begin
      cycle(0, 0, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL store_rand[%0d] got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_clear();
    int busy_cycles;
    logic [15:0] io_before;
    for (int n = 0; n < 8; n++) cycle(0, 0, 1, 8'(n), 16'hA0A0 + 16'(n));
    io_before = bus.IO64_OUT;
    cycle(0, 1, 0, 0, 0);
    busy_cycles = (bus.BUSY === 1'b1) ? 1 : 0;
    for (int n = 0; n < 10; n++) begin
      cycle(0, 0, 0, 0, 0);
      if (bus.BUSY === 1'b1) busy_cycles++;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL clear_seq[%0d] got=%h exp=%h", n, dut_vec(), model_vec());
      end
    end
    n_checks++;
    if (busy_cycles != 8) begin
      n_fail++;
      $display("FAIL clear_busy_len got=%0d exp=8", busy_cycles);
    end
    n_checks++;
    if (bus.IO64_OUT !== io_before) begin
      n_fail++;
      $display("FAIL clear_io64 got=%h exp=%h", bus.IO64_OUT, io_before);
    end
  endtask

  task automatic test_io64();
    cycle(0, 0, 1, 8'h40, 16'h5555);
    n_checks++;
    if (bus.IO64_OUT !== 16'h5555 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL io64_store got=%h exp=%h", dut_vec(), model_vec());
    end
    cycle(0, 0, 1, 8'h41, 16'hBEEF);
    n_checks++;
    if (bus.WR_DROP !== 1'b1 || bus.IO64_OUT !== 16'h5555 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL io65_drop got=%h exp=%h", dut_vec(), model_vec());
    end
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (bus.WR_DROP !== 1'b0) begin
      n_fail++;
      $display("FAIL io65_drop_len got=%b exp=0", bus.WR_DROP);
    end
  endtask

  task automatic test_collision();
    int drops;
    drops = 0;
    cycle(0, 0, 1, 8'h02, 16'h7777);
    cycle(0, 1, 1, 8'h02, 16'h1111);
    if (bus.WR_DROP === 1'b1) drops++;
    for (int n = 1; n <= 10; n++) begin
      // 4th CLEAR cycle gets a store; a CLR_REQ in the 6th must be ignored.
      cycle(0, (n == 6), (n == 4), 8'h02, 16'h2222);
      if (bus.WR_DROP === 1'b1) drops++;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL collide[%0d] got=%h exp=%h", n, dut_vec(), model_vec());
      end
    end
    n_checks++;
    if (drops != 2) begin
      n_fail++;
      $display("FAIL collide_drops got=%0d exp=2", drops);
    end
    n_checks++;
    if (bus.RAM_2 !== 16'h0000 || bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_end got=%h/%b exp=0000/0", bus.RAM_2, bus.BUSY);
    end
  endtask

  task automatic test_reset_mid_clear();
    cycle(0, 0, 1, 8'h05, 16'h00FF);
    cycle(0, 0, 1, 8'h40, 16'hCAFE);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 1, 8'h05, 16'h1234);
    n_checks++;
    if (dut_vec() !== '0 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_clear got=%h exp=0", dut_vec());
    end
    cycle(0, 0, 1, 8'h05, 16'h4321);
    n_checks++;
    if (bus.RAM_5 !== 16'h4321 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL after_reset_store got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

`ifdef RAM_WB_IO64_STB_EN
  task automatic test_io64_stb();
    int pulses;
    pulses = 0;
    cycle(0, 0, 1, 8'h40, 16'h0001);
    if (bus.IO64_STB === 1'b1) pulses++;
    cycle(0, 0, 1, 8'h40, 16'h0001);
    if (bus.IO64_STB === 1'b1) pulses++;
    cycle(0, 0, 0, 8'h40, 16'h0001);
    if (bus.IO64_STB === 1'b1) pulses++;
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL io64_stb_pulses got=%0d exp=2", pulses);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random[%0d] got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    bus.CLR_REQ = 1'b0;
    bus.RAM_WEN = 1'b0;
    bus.RAM_AD_IN = '0;
    bus.RAM_IN = '0;
    for (int i = 0; i < 8; i++) m_ram[i] = 16'h0;
    m_io = 16'h0;
    m_clear_left = 0;
    m_drop = 1'b0;
    m_stb = 1'b0;
    @(negedge clk);
    test_reset();
    test_store();
    test_clear();
    test_io64();
    test_collision();
    test_reset_mid_clear();
`ifdef RAM_WB_IO64_STB_EN
    test_io64_stb();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
